// File: rtl/hazard_unit_pkg.sv
// Shared constants and types for the hazard unit and its long-op scoreboard.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hazard_unit_pkg;

    // Operand mux selects driven back to the decode stage
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Integer x0; writes to it are discarded so it never creates a hazard
    localparam logic [5:0] REG_ZERO = 6'd0;

    // Default issue-to-writeback distance for fdiv/fsqrt class ops
    localparam int LONG_LAT_DEF = 4;

    typedef enum logic {
        SB_IDLE,
        SB_BUSY
    } sb_state_t;

endpackage

// File: rtl/hazard_unit_long_scoreboard.sv
// One-entry scoreboard tracking a single in-flight long-latency FPU result.
// Latency: busy from the edge after issue for LONG_LAT cycles; hazards are combinational.
// Backpressure: raises lhaz/lstr so the hazard unit stalls decode; never accepts a second op.
module long_scoreboard
    import hazard_unit_pkg::*;
#(
    parameter int LONG_LAT = LONG_LAT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       d_valid,
    input  logic       d_long,
    input  logic       issue,
    input  logic [5:0] rs0,
    input  logic [5:0] rs1,
    input  logic [5:0] rd,
    input  logic       rs0_used,
    input  logic       rs1_used,
    output logic       long_busy,
    output logic       lhaz,
    output logic       lstr
);

    localparam int CW = $clog2(LONG_LAT);

    sb_state_t     state;
    logic [5:0]    long_rd;
    logic [CW-1:0] long_cnt;

    // Busy/countdown FSM; busy stays high through the writeback cycle (cnt==0)
    // because the register file has no write-through.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SB_IDLE;
            long_busy <= 1'b0;
            long_rd   <= REG_ZERO;
            long_cnt  <= '0;
        end else begin
            case (state)
                SB_IDLE: begin
                    if (issue && d_long) begin
                        state     <= SB_BUSY;
                        long_busy <= 1'b1;
                        long_rd   <= rd;
                        long_cnt  <= CW'(LONG_LAT - 1);
                    end
                end
                SB_BUSY: begin
                    if (long_cnt == '0) begin
                        state     <= SB_IDLE;
                        long_busy <= 1'b0;
                    end else begin
                        long_cnt <= long_cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= SB_IDLE;
                    long_busy <= 1'b0;
                end
            endcase
        end
    end

    // RAW on either source or WAW on the destination against the pending result
    assign lhaz = d_valid && long_busy && (long_rd != REG_ZERO) &&
                  ((rs0_used && (rs0 == long_rd)) ||
                   (rs1_used && (rs1 == long_rd)) ||
                   (rd == long_rd));

    // Only one long op may be in flight, regardless of registers touched
    assign lstr = d_valid && d_long && long_busy;

endmodule

// File: rtl/hazard_unit.sv
// Decode-side hazard control: forward selects, load-use and long-op stalls, stall counter.
// Latency: forward0/1 and stall are combinational; stall_cycles updates on the next edge.
// Backpressure: stall holds F/D and injects a bubble into E; counter saturates at all-ones.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int LONG_LAT = LONG_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       rs0,
    input  logic [5:0]       rs1,
    input  logic [5:0]       rd,
    input  logic             rs0_used,
    input  logic             rs1_used,
    input  logic             d_valid,
    input  logic             d_long,
    input  logic [5:0]       rdE,
    input  logic             regwriteE,
    input  logic             memreadE,
    input  logic [5:0]       rdM,
    input  logic             regwriteM,
    output logic [1:0]       forward0,
    output logic [1:0]       forward1,
    output logic             stall,
    output logic             long_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic luse;
    logic lhaz;
    logic lstr;
    logic issue;

    // E beats M; a load in E has no data yet so it is never an E forward source
    function automatic logic [1:0] fwd_sel(
        input logic [5:0] r,
        input logic [5:0] rd_e,
        input logic       wr_e,
        input logic       ld_e,
        input logic [5:0] rd_m,
        input logic       wr_m
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (r != REG_ZERO) begin
            if (wr_e && !ld_e && (rd_e == r))
                sel = FWD_E;
            else if (wr_m && (rd_m == r))
                sel = FWD_M;
        end
        return sel;
    endfunction

    // Forward selects for both decode sources
    always_comb begin
        forward0 = fwd_sel(rs0, rdE, regwriteE, memreadE, rdM, regwriteM);
        forward1 = fwd_sel(rs1, rdE, regwriteE, memreadE, rdM, regwriteM);
    end

    // One-bubble load-use: next cycle the load sits in M and forwards from there
    assign luse = d_valid && memreadE && regwriteE && (rdE != REG_ZERO) &&
                  ((rs0_used && (rdE == rs0)) || (rs1_used && (rdE == rs1)));

    assign stall = luse || lhaz || lstr;
    assign issue = d_valid && !stall;

    long_scoreboard #(
        .LONG_LAT (LONG_LAT)
    ) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .d_valid   (d_valid),
        .d_long    (d_long),
        .issue     (issue),
        .rs0       (rs0),
        .rs1       (rs1),
        .rd        (rd),
        .rs0_used  (rs0_used),
        .rs1_used  (rs1_used),
        .long_busy (long_busy),
        .lhaz      (lhaz),
        .lstr      (lstr)
    );

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          clk;
    logic          rstn;
    logic [5:0]    rs0, rs1, rd, rdE, rdM;
    logic          rs0_used, rs1_used, d_valid, d_long;
    logic          regwriteE, memreadE, regwriteM;
    logic [1:0]    forward0, forward1;
    logic          stall, long_busy;
    logic [CW-1:0] stall_cycles;

    hazard_unit #(.LONG_LAT(4), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .rs0(rs0), .rs1(rs1), .rd(rd),
        .rs0_used(rs0_used), .rs1_used(rs1_used), .d_valid(d_valid), .d_long(d_long),
        .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
        .rdM(rdM), .regwriteM(regwriteM),
        .forward0(forward0), .forward1(forward1), .stall(stall),
        .long_busy(long_busy), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic       dv, dl;
        logic [5:0] r0; logic u0;
        logic [5:0] r1; logic u1;
        logic [5:0] rdd, rde; logic we, me;
        logic [5:0] rdm; logic wm;
    } stim_t;

    typedef struct {
        logic [1:0]    f0, f1;
        logic          st, busy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    function automatic stim_t mk_s(logic dv, logic dl, logic [5:0] r0, logic u0,
                                   logic [5:0] r1, logic u1, logic [5:0] rdd,
                                   logic [5:0] rde, logic we, logic me,
                                   logic [5:0] rdm, logic wm);
        stim_t s;
        s.dv = dv; s.dl = dl; s.r0 = r0; s.u0 = u0; s.r1 = r1; s.u1 = u1;
        s.rdd = rdd; s.rde = rde; s.we = we; s.me = me; s.rdm = rdm; s.wm = wm;
        return s;
    endfunction

    function automatic exp_t mk_e(logic [1:0] f0, logic [1:0] f1, logic st, logic busy);
        exp_t e;
        e.f0 = f0; e.f1 = f1; e.st = st; e.busy = busy; e.cnt = '0;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        d_valid = s.dv; d_long = s.dl;
        rs0 = s.r0; rs0_used = s.u0; rs1 = s.r1; rs1_used = s.u1; rd = s.rdd;
        rdE = s.rde; regwriteE = s.we; memreadE = s.me;
        rdM = s.rdm; regwriteM = s.wm;
    endtask

    // Push the expectation with the modelled counter, then advance the model
    task automatic push_exp(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.cnt = exp_cnt;
        q.push_back(e);
        if (e.st && exp_cnt != CNT_MAX)
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0;
        drive(mk_s(0,0, 0,0, 0,0, 0, 0,0,0, 0,0));
        push_exp(mk_e(2'b00, 2'b00, 1'b0, 1'b0));
        #3;
        e = q.pop_front(); n_vec++;
        if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
            long_busy !== e.busy || stall_cycles !== e.cnt) begin
            n_err++;
            $display("FAIL reset: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                     forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_forward();
        stim_t s[7];
        exp_t  x[7];
        exp_t  e;
        s[0] = mk_s(1,0,  5,1,  0,0, 0,  5,1,0,  5,1); x[0] = mk_e(2'b01, 2'b00, 0, 0);
        s[1] = mk_s(1,0,  5,1,  0,0, 0,  5,0,0,  5,1); x[1] = mk_e(2'b10, 2'b00, 0, 0);
        s[2] = mk_s(1,0,  0,0,  0,1, 0,  0,1,0,  0,0); x[2] = mk_e(2'b00, 2'b00, 0, 0);
        s[3] = mk_s(1,0,  0,0, 32,1, 0, 32,1,0,  0,0); x[3] = mk_e(2'b00, 2'b01, 0, 0);
        s[4] = mk_s(1,0,  9,0,  9,0, 0,  9,1,1,  9,1); x[4] = mk_e(2'b10, 2'b10, 0, 0);
        s[5] = mk_s(0,0, 12,1, 12,1, 0, 12,1,0, 12,1); x[5] = mk_e(2'b01, 2'b01, 0, 0);
        s[6] = mk_s(1,0,  0,1,  3,1, 0,  3,0,0,  0,1); x[6] = mk_e(2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL forward[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        exp_t  x[6];
        exp_t  e;
        s[0] = mk_s(1,0, 7,1, 3,1, 8, 7,1,1, 0,0); x[0] = mk_e(2'b00, 2'b00, 1, 0);
        s[1] = mk_s(1,0, 7,1, 3,1, 8, 0,0,0, 7,1); x[1] = mk_e(2'b10, 2'b00, 0, 0);
        s[2] = mk_s(1,0, 3,1, 7,1, 8, 7,1,1, 0,0); x[2] = mk_e(2'b00, 2'b00, 1, 0);
        s[3] = mk_s(1,0, 3,1, 7,0, 8, 7,1,1, 0,0); x[3] = mk_e(2'b00, 2'b00, 0, 0);
        s[4] = mk_s(1,0, 0,1, 0,1, 8, 0,1,1, 0,0); x[4] = mk_e(2'b00, 2'b00, 0, 0);
        s[5] = mk_s(0,0, 7,1, 3,1, 8, 7,1,1, 0,0); x[5] = mk_e(2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL load_use[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_long_raw();
        stim_t s[6];
        exp_t  x[6];
        exp_t  e;
        s[0] = mk_s(1,1, 0,0, 0,0, 40, 0,0,0, 0,0); x[0] = mk_e(2'b00, 2'b00, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            s[k] = mk_s(1,0, 0,0, 40,1, 41, 0,0,0, 0,0); x[k] = mk_e(2'b00, 2'b00, 1, 1);
        end
        s[5] = mk_s(1,0, 0,0, 40,1, 41, 0,0,0, 0,0); x[5] = mk_e(2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL long_raw[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back_long();
        stim_t s[11];
        exp_t  x[11];
        exp_t  e;
        s[0] = mk_s(1,1, 0,0, 0,0, 44, 0,0,0, 0,0); x[0] = mk_e(2'b00, 2'b00, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            s[k] = mk_s(1,1, 1,1, 2,1, 45, 0,0,0, 0,0); x[k] = mk_e(2'b00, 2'b00, 1, 1);
        end
        s[5]  = mk_s(1,1,  1,1, 2,1, 45, 0,0,0, 0,0); x[5]  = mk_e(2'b00, 2'b00, 0, 0);
        s[6]  = mk_s(1,0, 45,1, 0,0, 46, 0,0,0, 0,0); x[6]  = mk_e(2'b00, 2'b00, 1, 1);
        s[7]  = mk_s(1,0, 44,1, 0,0, 46, 0,0,0, 0,0); x[7]  = mk_e(2'b00, 2'b00, 0, 1);
        s[8]  = mk_s(0,0,  0,0, 0,0,  0, 0,0,0, 0,0); x[8]  = mk_e(2'b00, 2'b00, 0, 1);
        s[9]  = mk_s(0,0,  0,0, 0,0,  0, 0,0,0, 0,0); x[9]  = mk_e(2'b00, 2'b00, 0, 1);
        s[10] = mk_s(0,0,  0,0, 0,0,  0, 0,0,0, 0,0); x[10] = mk_e(2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            drive(s[i]);
            push_exp(x[i]);
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[4];
        exp_t  x[4];
        exp_t  e;
        s[0] = mk_s(1,1,  0,0, 0,0, 50, 0,0,0, 0,0); x[0] = mk_e(2'b00, 2'b00, 0, 0);
        s[1] = mk_s(0,0,  0,0, 0,0,  0, 0,0,0, 0,0); x[1] = mk_e(2'b00, 2'b00, 0, 1);
        s[2] = mk_s(1,0, 50,1, 0,0, 51, 0,0,0, 0,0); x[2] = mk_e(2'b00, 2'b00, 1, 1);
        s[3] = mk_s(1,0, 50,1, 0,0, 51, 0,0,0, 0,0); x[3] = mk_e(2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                // long_cnt is 2 here; pull reset between edges
                #1 rstn = 1'b0;
                exp_cnt = '0;
                push_exp(x[i]);
                #1;
            end else begin
                @(posedge clk); #1;
                drive(s[i]);
                push_exp(x[i]);
                @(negedge clk);
            end
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
        #1 rstn = 1'b1;
    endtask

    task automatic test_saturate();
        stim_t sl, si;
        exp_t  e;
        sl = mk_s(1,0, 7,1, 0,0, 8, 7,1,1, 0,0);
        si = mk_s(0,0, 0,0, 0,0, 0, 0,0,0, 0,0);
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            if (i < 18) begin
                drive(sl);
                push_exp(mk_e(2'b00, 2'b00, 1, 0));
            end else begin
                drive(si);
                push_exp(mk_e(2'b00, 2'b00, 0, 0));
            end
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            if (forward0 !== e.f0 || forward1 !== e.f1 || stall !== e.st ||
                long_busy !== e.busy || stall_cycles !== e.cnt) begin
                n_err++;
                $display("FAIL saturate[%0d]: got f0=%b f1=%b st=%b busy=%b cnt=%0d, want f0=%b f1=%b st=%b busy=%b cnt=%0d",
                         i, forward0, forward1, stall, long_busy, stall_cycles, e.f0, e.f1, e.st, e.busy, e.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_long_raw();
        test_back_to_back_long();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Control-side counterpart of the decode stage's operand-forwarding interface.
- Consumes the decode stage's source register indices (rs0/rs1) and the E/M pipeline state, and generates the forward0/forward1 mux selects that decode applies to its read data.
- Also generates the decode stall for load-use hazards and for in-flight multi-cycle FPU results (fdiv/fsqrt class), tracked by an internal one-entry scoreboard.
- Register space is 6-bit: index 0 is integer x0 (never a hazard); 32..63 are float registers, and f0 (6'd32) is a real register.

Parameters:
- LONG_LAT, 4: cycles from long-op issue to its register-file write (min 2).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rs0  in  6  decode source 0 index
- rs1  in  6  decode source 1 index
- rd  in  6  decode destination index
- rs0_used  in  1  decode instr reads rs0
- rs1_used  in  1  decode instr reads rs1
- d_valid  in  1  decode holds a valid instr
- d_long  in  1  decode instr is a long-latency FPU op
- rdE  in  6  E-stage destination
- regwriteE  in  1  E-stage writes rd
- memreadE  in  1  E-stage is a load
- rdM  in  6  M-stage destination
- regwriteM  in  1  M-stage writes rd
- forward0  out  2  00 regfile, 01 E result, 10 M result
- forward1  out  2  same, for rs1
- stall  out  1  hold F/D, inject bubble into E
- long_busy  out  1  scoreboard entry valid
- stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn. Reset clears long_busy, long_rd, long_cnt and stall_cycles to 0. forward0/1 are combinational, so they read 00 whenever the inputs do not match.
- Forward select, per source s in {0,1} with index r:
  - 01 if regwriteE & rdE==r & r!=0 & !memreadE;
  - else 10 if regwriteM & rdM==r & r!=0;
  - else 00.
  - E has priority over M. Forwarding is purely combinational, with zero latency.
- Load-use: luse = d_valid & memreadE & regwriteE & rdE!=0 & ((rs0_used & rdE==rs0) | (rs1_used & rdE==rs1)). One bubble; the next cycle the load is in M and forward selects 10.
- Long RAW/WAW: lhaz = d_valid & long_busy & long_rd!=0 & (rs0_used & rs0==long_rd | rs1_used & rs1==long_rd | rd==long_rd).
- Long structural: lstr = d_valid & d_long & long_busy.
- stall = luse | lhaz | lstr (combinational).
- Issue: issue = d_valid & !stall. On issue & d_long, next edge sets long_busy=1, long_rd=rd, long_cnt=LONG_LAT-1.
- Scoreboard states:
  - IDLE (long_busy=0).
  - BUSY: long_cnt decrements by 1 each cycle.
  - In the cycle with long_cnt==0, the result is written to the register file. long_busy is still 1 in that cycle, so dependents stall.
  - The next edge clears long_busy (back to IDLE).
  - The register file has no write-through, so the dependent reads it the cycle after completion with forward=00.
- Same-cycle completion and new long op: the new op stalls (lstr), because long_busy is still high. It issues the following cycle. There are no back-to-back overlapped long ops.
- A long op with rd==0 still occupies the scoreboard (structural) but creates no RAW/WAW.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- Reset mid-operation clears the scoreboard immediately. The in-flight long op is discarded by the pipeline reset.

Decomposition:
- Shared package (def.sv): FWD_RF=2'b00, FWD_E=2'b01, FWD_M=2'b10; REG_ZERO=6'd0; LONG_LAT default.
- Sub-module: long_scoreboard (busy/rd/counter FSM, hazard compare). Forward-select logic stays in hazard_unit.

Test Plan:
- rs0=5, rs0_used=1; E: rdE=5, regwriteE=1, memreadE=0; M: rdM=5, regwriteM=1 -> forward0=01, stall=0. With regwriteE=0 -> forward0=10.
- rs1=0, rs1_used=1; regwriteE=1, rdE=0 -> forward1=00, stall=0 (x0 never forwarded). With rs1=32, rdE=32 -> forward1=01.
- Load in E with rdE=7, memreadE=1; decode rs0=7, rs0_used=1 -> stall=1 for exactly 1 cycle, stall_cycles +1. Next cycle with rdM=7 -> forward0=10, stall=0.
- Long op issued with rd=40, LONG_LAT=4; next instr reads rs1=40 -> long_busy high 4 cycles, stall=1 for 4 cycles; dependent issues on the 5th cycle with forward1=00.
- Second d_long arrives while long_busy=1 (no register overlap) -> stall until long_busy clears, then issue; long_rd updates to the new rd.
- rstn pulsed low while long_busy=1 and long_cnt=2 -> long_busy=0, stall_cycles=0, stall=0 immediately (asynchronous).
